// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO and send sequencer in front of the UART transmitter; UART_TX_FEEDER_OVF_COUNT_EN builds ovf_count.
// Latency: byte written into an empty idle FIFO drives tx_send two edges later; frame-to-frame turnaround is 3 edges plus GAP_CYCLES.
// Backpressure: none toward the producer except full; a write while full with no same-cycle pop is dropped and sets overflow.
module uart_tx_feeder #(
    parameter int DEPTH_LOG2 = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic [7:0]            ovf_count,
    output logic [7:0]            tx_data,
    output logic                  tx_send,
    input  logic                  tx_active,
    input  logic                  tx_done,
    output logic                  busy
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [15:0] GAP_LAST = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [7:0]            pop_dat;
    logic                  pop;
    logic                  wr_acc;
    logic                  wr_drop;
    logic                  done_q;
    logic                  done_rise;
    logic [15:0]           gap_cnt;

    assign full      = (level == FULL_LEVEL);
    assign empty     = (level == '0);
    assign wr_acc    = wr_en & (~full | pop);
    assign wr_drop   = wr_en & full & ~pop;
    assign done_rise = tx_done & ~done_q;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Popped byte is captured at the pop edge: a simultaneous write into a full
    // FIFO lands in the very slot being popped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pop_dat <= 8'h00;
        end else if (pop) begin
            pop_dat <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_acc, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (wr_drop) begin
            overflow <= 1'b1;
        end
    end

`ifdef UART_TX_FEEDER_OVF_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_count <= 8'h00;
        end else if (wr_drop && (ovf_count != 8'hFF)) begin
            ovf_count <= ovf_count + 8'd1;
        end
    end
`else
    assign ovf_count = 8'h00;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: state_nxt = S_SEND;
            S_SEND: begin
                if (tx_active) begin
                    state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (done_rise) begin
                    state_nxt = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // done_q samples every cycle so a level held over from the last frame
    // never looks like a fresh rising edge once WAIT_DONE is entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_data <= 8'h00;
            tx_send <= 1'b0;
            done_q  <= 1'b0;
            gap_cnt <= '0;
        end else begin
            done_q  <= tx_done;
            tx_send <= (state_nxt == S_SEND);
            if (state == S_LOAD) begin
                tx_data <= pop_dat;
            end
            if (state == S_GAP) begin
                gap_cnt <= gap_cnt + 16'd1;
            end else begin
                gap_cnt <= '0;
            end
        end
    end

endmodule

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Byte buffer and send sequencer upstream of the UART transmitter in the full-duplex top. It accepts bytes from a producer (CPU, test pattern generator or RX loopback path) into a FIFO and hands them one at a time to the transmitter. For each byte it presents the byte, raises the transmitter's send request, waits for the frame to start and finish, then optionally inserts an idle gap before the next byte.

## Interface
- DEPTH_LOG2, default 4: FIFO depth is 2**DEPTH_LOG2 bytes, 16 by default. Legal range is 1..8.
- GAP_CYCLES, default 0: idle clk cycles inserted after each frame completes. Legal range is 0..65535.

- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  producer write strobe. Sampled on the clk rising edge.
- wr_data  in  8  byte to enqueue.
- full  out  1  FIFO holds 2**DEPTH_LOG2 bytes.
- empty  out  1  FIFO holds 0 bytes.
- level  out  DEPTH_LOG2+1  current FIFO occupancy.
- overflow  out  1  sticky flag: a write was dropped.
- ovf_count  out  8  dropped-write counter (see Configuration).
- tx_data  out  8  byte presented to the transmitter's data input. Held stable from LOAD until the next LOAD.
- tx_send  out  1  send request to the transmitter.
- tx_active  in  1  transmitter active flag.
- tx_done  in  1  transmitter done flag.
- busy  out  1  high in any state other than IDLE.

## Operation
- The FIFO is a circular buffer with rd_ptr and wr_ptr, each DEPTH_LOG2 bits wide, plus a level counter of DEPTH_LOG2+1 bits. Pointers wrap modulo depth.
- Write rule: a write is accepted when wr_en=1 and either (full=0) or (a pop occurs in the same cycle).
  - An accepted write stores wr_data at wr_ptr and increments wr_ptr.
  - A write with wr_en=1 while full and no pop is dropped. It sets overflow, and overflow stays set until rst.
- Pop rule: a pop occurs only in IDLE when empty=0.
- level changes by +1 for a write only, -1 for a pop only, and 0 for a simultaneous write and pop.
- FSM states:
  - IDLE: if empty=0, pop, go to LOAD.
  - LOAD: register tx_data from the popped entry, go to SEND.
  - SEND: tx_send=1. When tx_active is sampled 1, go to WAIT_DONE.
  - WAIT_DONE: tx_send=0. On a rising edge of tx_done (previous sample 0, current sample 1), go to GAP if GAP_CYCLES>0, otherwise go to IDLE.
  - GAP: a 16-bit counter counts to GAP_CYCLES-1, then the FSM goes to IDLE.
- tx_done level is ignored outside WAIT_DONE. A done flag still high from the previous frame must not complete the next one; only a rising edge inside WAIT_DONE does.
- Writes are accepted in every state, so the producer never stalls except on full.

## Timing
- Reset values: full=0, empty=1, level=0, overflow=0, ovf_count=0, tx_data=0x00, tx_send=0, busy=0, state IDLE, both pointers 0.
- Reset takes effect immediately (asynchronous). Reset mid-frame discards FIFO contents and drops tx_send at once. The in-flight transmitter frame is not the feeder's concern.
- Write latency: a write accepted at edge w is reflected in level, empty and full after edge w.
- Write into an empty FIFO while IDLE, accepted at edge w:
  - edge w+1: pop, state LOAD.
  - edge w+2: tx_data valid, tx_send=1.
- tx_send is registered. It deasserts on the edge after tx_active is sampled high.
- Back-to-back bytes with GAP_CYCLES=0: the next tx_send rises 3 edges after the tx_done rising edge is sampled (WAIT_DONE→IDLE, IDLE→LOAD, LOAD→SEND).
- Full and empty are exact. There is no almost-full threshold.

## Configuration
- Macro: UART_TX_FEEDER_OVF_COUNT_EN.
- Defined: ovf_count increments on each dropped write and saturates at 255. It is cleared only by rst.
- Undefined: ovf_count is tied to 8'h00 and no counter logic is built. The overflow sticky flag is present in both builds.

## Test plan
- Single byte: write 0xA5 into an empty FIFO.
  - tx_send rises 2 cycles later with tx_data=0xA5.
  - Model tx_active high 3 cycles later, then tx_done pulse: tx_send drops 1 cycle after tx_active; busy drops 1 cycle after the tx_done rise.
- Ordering: write 0x01..0x10 back-to-back with DEPTH_LOG2=4.
  - full=1 and level=16 after the 16th write.
  - Transmitted sequence is 0x01..0x10 in order, with no gaps beyond the 3-cycle turnaround.
- Overflow, with the macro defined:
  - Fill 16 entries and hold the transmitter model so it never asserts active.
  - Write 300 more bytes: overflow=1, ovf_count=255, level stays 16 after the first pop.
  - Without the macro, ovf_count stays 0.
- Simultaneous write and pop: with the FIFO full and IDLE popping, write 0x77 in the same cycle.
  - Write accepted, level stays 16, overflow stays 0.
  - 0x77 is later sent last.
- Stale done and gap: hold tx_done=1 continuously from the previous frame, GAP_CYCLES=5.
  - The FSM stays in WAIT_DONE until tx_done falls and rises again.
  - The next tx_send rises 5+3 cycles after that rising edge.
- Reset mid-frame: assert rst in SEND with level=4.
  - tx_send=0, level=0, empty=1 and busy=0 immediately.
  - No byte is sent after rst is released.
